// File: rtl/seq_det_param.sv
// Serial N-bit pattern detector with a loadable pattern, overlapping or
// non-overlapping detection, a registered match pulse and a saturating match counter.
module seq_det_param #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in,
  input  logic          in_valid,
  input  logic [N-1:0]  pat,
  input  logic          pat_ld,
  input  logic          overlap,
  input  logic          clr_cnt,
  output logic          out,
  output logic [CW-1:0] match_cnt,
  output logic          busy
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] F_FULL = FW'(N);
  localparam logic [N-1:0]  PR_RST = N'(1) | (N'(1) << (N - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  logic [N-1:0]  pr_q, pr_d;
  // Only the N-1 most recent bits ever reach a comparison, so the oldest
  // history bit is not kept.
  logic [N-2:0]  h_q, h_d;
  logic [FW-1:0] f_q, f_d;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;

  logic [N-1:0]  window;
  logic          accept;
  logic          match;

  always_comb begin
    window  = {h_q, in};
    accept  = in_valid && !pat_ld;
    match   = accept && (window == pr_q) && (f_q >= F_FULL - FW'(1));

    pr_d    = pr_q;
    h_d     = h_q;
    f_d     = f_q;
    out_d   = 1'b0;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (pat_ld) begin
      pr_d = pat;
      f_d  = '0;
    end else if (accept) begin
      h_d   = window[N-2:0];
      out_d = match;
      if (match) begin
        f_d = overlap ? F_FULL : '0;
      end else if (f_q != F_FULL) begin
        f_d = f_q + FW'(1);
      end
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match && !(&cnt_q)) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (f_d == '0) begin
      state_d = IDLE;
    end else if (f_d == F_FULL) begin
      state_d = ARMED;
    end else begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q    <= PR_RST;
      h_q     <= '0;
      f_q     <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      pr_q    <= pr_d;
      h_q     <= h_d;
      f_q     <= f_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter N, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter CW, default 8: width of the match counter.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in, input, 1 bit: serial data bit.
REQ-006 Port in_valid, input, 1 bit: `in` is sampled only when this is 1; otherwise the cycle is ignored.
REQ-007 Port pat, input, N bits: pattern to load; pat[N-1] is the first bit expected.
REQ-008 Port pat_ld, input, 1 bit: latches `pat` into the internal pattern register.
REQ-009 Port overlap, input, 1 bit: 1 = overlapping detection; 0 = non-overlapping detection.
REQ-010 Port clr_cnt, input, 1 bit: clears the match counter.
REQ-011 Port out, output, 1 bit: registered one-cycle match pulse.
REQ-012 Port match_cnt, output, CW bits: saturating count of matches.
REQ-013 Port busy, output, 1 bit: 1 while the fill count is nonzero (a partial or complete history is held).

Function
REQ-014 The block SHALL hold the following state: pattern register PR (N bits), history shift register H (N bits), fill counter F (0..N), out register, and match_cnt.
REQ-015 On an accepted bit (in_valid=1, pat_ld=0), the block SHALL update H <= {H[N-2:0], in} and F <= min(F+1, N).
REQ-016 Match condition: in the same accepted cycle, {H[N-2:0], in} == PR and F >= N-1.
REQ-017 On a match, out SHALL be 1 in the cycle after the edge that sampled the last pattern bit; latency is 1 clock.
REQ-018 Out SHALL be 0 in every cycle that does not follow a match, including cycles after in_valid=0.
REQ-019 Overlap mode (overlap=1): after a match, F SHALL stay at N, so shared suffix/prefix bits can form the next match.
REQ-020 Non-overlap mode (overlap=0): the match edge SHALL set F to 0, so N fresh accepted bits are needed before the next match; H still shifts.
REQ-021 overlap SHALL be sampled every cycle; a change affects only the next match decision, and H and F are not flushed.
REQ-022 pat_ld=1 SHALL perform PR <= pat, F <= 0, and out <= 0; any in_valid bit in that cycle is discarded (pat_ld has priority).
REQ-023 match_cnt SHALL increment by 1 on each match and saturate at 2^CW-1 without wrapping.
REQ-024 clr_cnt=1 SHALL set match_cnt to 0; if a match occurs in the same cycle, clear wins and the count is 0, but out still pulses.
REQ-025 The FSM view is IDLE (F=0), FILL (0<F<N), and ARMED (F=N); busy = (F != 0).
REQ-026 A pattern of all 0s or all 1s SHALL be legal and detected like any other pattern.

Reset
REQ-027 rst=1 at a clock edge SHALL set H=0, F=0, out=0, match_cnt=0, and PR to the value 1 followed by N-2 zeros and a final 1 (1001 for N=4).
REQ-028 rst SHALL have priority over pat_ld, clr_cnt, and in_valid.
REQ-029 Reset asserted mid-pattern SHALL discard all partial history; detection restarts from IDLE.
REQ-030 No output SHALL be X after the first reset edge.

Verification
REQ-031 N=4, reset-default PR=1001, overlap=1, stream 1,0,0,1,0,0,1 (in_valid=1 every cycle) -> out pulses after bits 4 and 7; match_cnt=2.
REQ-032 Same stream with overlap=0 -> single out pulse after bit 4; match_cnt=1; F=3 at end.
REQ-033 Stream 1,0,0,1 with in_valid=0 cycles inserted between every bit -> exactly one out pulse, one cycle after the 4th accepted bit; no pulse during idle cycles.
REQ-034 pat_ld with pat=0110, then stream 0,1,1,0,1,1,0 with overlap=1 -> 2 pulses; a pat_ld issued mid-stream after 0,1,1 followed by 0 -> no pulse (history flushed).
REQ-035 CW=2, overlap=1, pattern 1111, five 1s then seven 1s -> match_cnt reaches 3 and holds 3; clr_cnt in a match cycle -> match_cnt=0 and out=1.
REQ-036 rst asserted after 1,0,0 then stream 1 -> no pulse; F=1; match_cnt=0; PR=1001.
